esm_issue_window: RTL and testbench

//  Parametrised successor to the single-entry ESM hazard checker. Buffers up to DEPTH decoded
//  RV32 instructions in a circular window. Issues the oldest hazard-free entry each cycle:
//  RAW/WAW/WAR checks run against older window entries and a register busy scoreboard.

---
 rtl/esm_issue_window.sv | 170 +++++++++++++++++
 tb/tb_esm_issue_window.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_window.sv
// Out-of-order capable issue window: buffers decoded RV32 instructions in a circular
// window and issues the oldest hazard-free entry into a registered output stage.
module esm_issue_window #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter bit OOO_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     in_regwrite,
  input  logic                     in_alusrc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  output logic [$clog2(DEPTH):0]   count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready. A producer
  // never waits for ready before raising valid, and out_instr is held stable while
  // out_valid && !out_ready.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [AW-1:0] ptr_t;

  logic [DEPTH-1:0] slot_valid;
  logic [XLEN-1:0]  slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_wr;
  logic [DEPTH-1:0] slot_rd2;
  ptr_t             head;
  ptr_t             tail;
  logic [31:0]      busy;

  logic [4:0]       f_rd  [DEPTH];
  logic [4:0]       f_rs1 [DEPTH];
  logic [4:0]       f_rs2 [DEPTH];
  ptr_t             age   [DEPTH];
  logic [DEPTH-1:0] blocked;

  logic             load;
  logic             enq;
  logic             sel_found;
  logic             sel_fire;
  ptr_t             sel_idx;
  ptr_t             scan_idx;
  logic [4:0]       sel_rd;
  logic             head_adv;
  logic [CW-1:0]    count_nxt;

  assign in_ready = !slot_valid[tail];
  assign enq      = in_valid && in_ready && !flush;
  assign load     = !flush && (!out_valid || out_ready);
  assign sel_fire = load && sel_found;
  assign sel_rd   = f_rd[sel_idx];

  // Age is the distance from head; modular subtraction keeps it valid across the wrap.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      f_rd[i]  = slot_instr[i][11:7];
      f_rs1[i] = slot_instr[i][19:15];
      f_rs2[i] = slot_instr[i][24:20];
      age[i]   = ptr_t'(i) - head;
    end
  end

  // x0 never hazards: slot_wr excludes rd=0 and busy[0] is never set.
  always_comb begin
    blocked = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (busy[f_rs1[e]] || (slot_rd2[e] && busy[f_rs2[e]]) || (slot_wr[e] && busy[f_rd[e]]))
        blocked[e] = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != e && slot_valid[j] && (age[j] < age[e])) begin
          if (slot_wr[j] && ((f_rd[j] == f_rs1[e]) ||
                             (slot_rd2[e] && (f_rd[j] == f_rs2[e])) ||
                             (slot_wr[e] && (f_rd[j] == f_rd[e]))))
            blocked[e] = 1'b1;
          if (slot_wr[e] && ((f_rs1[j] == f_rd[e]) ||
                             (slot_rd2[j] && (f_rs2[j] == f_rd[e]))))
            blocked[e] = 1'b1;
        end
      end
    end
  end

  // Scan from head so the first eligible hit is the oldest one.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = head;
    scan_idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + ptr_t'(k);
      if (!sel_found && slot_valid[scan_idx] && !blocked[scan_idx] && (OOO_EN || k == 0)) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  // Head also steps when its own entry issues, so in-order mode sustains one issue per cycle.
  always_comb begin
    head_adv = (!slot_valid[head] || (sel_fire && (sel_idx == head))) &&
               ((head != tail) || (|slot_valid));
  end

  always_comb begin
    count_nxt = count;
    if (enq && !sel_fire)
      count_nxt = (count == CW'(DEPTH)) ? count : count + 1'b1;
    else if (!enq && sel_fire)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      head       <= '0;
      tail       <= '0;
      busy       <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      count      <= '0;
    end else begin
      // Clear before set so a same-edge set on the same register wins.
      if (wb_valid && (wb_rd != 5'd0))
        busy[wb_rd] <= 1'b0;
      if (sel_fire && slot_wr[sel_idx])
        busy[sel_rd] <= 1'b1;

      if (flush) begin
        slot_valid <= '0;
        head       <= '0;
        tail       <= '0;
        out_valid  <= 1'b0;
        count      <= '0;
      end else begin
        if (load) begin
          out_valid <= sel_found;
          if (sel_found)
            out_instr <= slot_instr[sel_idx];
        end
        if (sel_fire)
          slot_valid[sel_idx] <= 1'b0;
        if (enq) begin
          slot_valid[tail] <= 1'b1;
          tail             <= tail + 1'b1;
        end
        if (head_adv)
          head <= head + 1'b1;
        count <= count_nxt;
      end
    end
  end

  // Payload needs no reset: it is only observed through slot_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      slot_instr[tail] <= in_instr;
      slot_wr[tail]    <= in_regwrite && (in_instr[11:7] != 5'd0);
      slot_rd2[tail]   <= !in_alusrc;
    end
  end

endmodule

// File: tb/tb_esm_issue_window.sv
// Bench for esm_issue_window: an out-of-order DEPTH=4 copy and an in-order DEPTH=8 copy
// share stimulus; each is compared every cycle with a program-order reference model.
module tb_esm_issue_window;

  localparam int DA = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_regwrite;
  logic        in_alusrc;
  logic        out_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_instr;
  logic [2:0]  a_count;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_instr;
  logic [3:0]  b_count;

  int n_checks = 0;
  int n_errors = 0;
  int seq_ctr  = 0;

  // Reference state: index 0 models the DA/OOO copy, index 1 the DB/in-order copy.
  logic        m_v    [2][8];
  logic [31:0] m_ins  [2][8];
  logic        m_wr   [2][8];
  logic        m_rd2  [2][8];
  int          m_seq  [2][8];
  int          m_tail [2];
  logic [31:0] m_busy [2];
  logic        m_ov   [2];
  logic [31:0] m_oi   [2];

  always #5 clk = ~clk;

  esm_issue_window #(.XLEN(32), .DEPTH(DA), .OOO_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_regwrite(in_regwrite), .in_alusrc(in_alusrc),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .count(a_count)
  );

  esm_issue_window #(.XLEN(32), .DEPTH(DB), .OOO_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_regwrite(in_regwrite), .in_alusrc(in_alusrc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .count(b_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] i);  return i[11:7];  endfunction
  function automatic logic [4:0] rs1_of(input logic [31:0] i); return i[19:15]; endfunction
  function automatic logic [4:0] rs2_of(input logic [31:0] i); return i[24:20]; endfunction

  function automatic int depth_of(input int m);
    return (m == 0) ? DA : DB;
  endfunction

  // Does older instruction o conflict with younger instruction y (RAW, WAW or WAR)?
  function automatic bit conflicts(input int m, input int o, input int y);
    logic [4:0] yrd, y1, y2, ord, o1, o2;
    bit hit;
    yrd = rd_of(m_ins[m][y]); y1 = rs1_of(m_ins[m][y]); y2 = rs2_of(m_ins[m][y]);
    ord = rd_of(m_ins[m][o]); o1 = rs1_of(m_ins[m][o]); o2 = rs2_of(m_ins[m][o]);
    hit = 1'b0;
    if (m_wr[m][o] && y1 != 5'd0 && ord == y1) hit = 1'b1;
    if (m_wr[m][o] && m_rd2[m][y] && y2 != 5'd0 && ord == y2) hit = 1'b1;
    if (m_wr[m][o] && m_wr[m][y] && ord == yrd) hit = 1'b1;
    if (m_wr[m][y] && o1 == yrd) hit = 1'b1;
    if (m_wr[m][y] && m_rd2[m][o] && o2 == yrd) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit is_blocked(input int m, input int e);
    logic [4:0] r1, r2, rd;
    bit b;
    r1 = rs1_of(m_ins[m][e]); r2 = rs2_of(m_ins[m][e]); rd = rd_of(m_ins[m][e]);
    b = (r1 != 5'd0 && m_busy[m][r1]) ||
        (m_rd2[m][e] && r2 != 5'd0 && m_busy[m][r2]) ||
        (m_wr[m][e] && m_busy[m][rd]);
    for (int j = 0; j < 8; j++)
      if (m_v[m][j] && m_seq[m][j] < m_seq[m][e] && conflicts(m, j, e)) b = 1'b1;
    return b;
  endfunction

  // Oldest unblocked entry by program order; in-order copy may only take the oldest entry.
  function automatic int pick(input int m);
    int best, oldest;
    best = -1; oldest = -1;
    for (int e = 0; e < 8; e++)
      if (m_v[m][e] && (oldest < 0 || m_seq[m][e] < m_seq[m][oldest])) oldest = e;
    for (int e = 0; e < 8; e++)
      if (m_v[m][e] && (m == 0 || e == oldest) && !is_blocked(m, e))
        if (best < 0 || m_seq[m][e] < m_seq[m][best]) best = e;
    return best;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 8; j++) m_v[m][j] = 1'b0;
      m_tail[m] = 0; m_busy[m] = '0; m_ov[m] = 1'b0; m_oi[m] = '0;
    end
  endtask

  task automatic model_step(input int m);
    bit rdy;
    int sel;
    rdy = !m_v[m][m_tail[m]];
    sel = -1;
    if (flush) begin
      for (int j = 0; j < 8; j++) m_v[m][j] = 1'b0;
      m_tail[m] = 0;
      m_ov[m]   = 1'b0;
    end else begin
      if (!m_ov[m] || out_ready) begin
        sel     = pick(m);
        m_ov[m] = (sel >= 0);
        if (sel >= 0) begin
          m_oi[m]     = m_ins[m][sel];
          m_v[m][sel] = 1'b0;
        end
      end
      if (in_valid && rdy) begin
        m_v[m][m_tail[m]]   = 1'b1;
        m_ins[m][m_tail[m]] = in_instr;
        m_wr[m][m_tail[m]]  = in_regwrite && (rd_of(in_instr) != 5'd0);
        m_rd2[m][m_tail[m]] = !in_alusrc;
        m_seq[m][m_tail[m]] = seq_ctr;
        m_tail[m] = (m_tail[m] + 1) % depth_of(m);
      end
    end
    if (wb_valid && wb_rd != 5'd0) m_busy[m][wb_rd] = 1'b0;
    if (sel >= 0 && m_wr[m][sel]) m_busy[m][rd_of(m_oi[m])] = 1'b1;
  endtask

  task automatic compare_all();
    int ca, cb;
    ca = 0; cb = 0;
    for (int j = 0; j < 8; j++) begin
      if (m_v[0][j]) ca++;
      if (m_v[1][j]) cb++;
    end
    check("a.out_valid", 32'(a_out_valid), 32'(m_ov[0]));
    if (m_ov[0]) check("a.out_instr", a_out_instr, m_oi[0]);
    check("a.count", 32'(a_count), 32'(ca));
    check("a.in_ready", 32'(a_in_ready), 32'(!m_v[0][m_tail[0]]));
    check("b.out_valid", 32'(b_out_valid), 32'(m_ov[1]));
    if (m_ov[1]) check("b.out_instr", b_out_instr, m_oi[1]);
    check("b.count", 32'(b_count), 32'(cb));
    check("b.in_ready", 32'(b_in_ready), 32'(!m_v[1][m_tail[1]]));
  endtask

  task automatic drive_cycle(input bit iv, input logic [31:0] ins, input bit rw, input bit as,
                             input bit ordy, input bit wv, input logic [4:0] wr, input bit fl);
    in_valid = iv; in_instr = ins; in_regwrite = rw; in_alusrc = as;
    out_ready = ordy; wb_valid = wv; wb_rd = wr; flush = fl;
    @(posedge clk);
    model_step(0);
    model_step(1);
    seq_ctr++;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, ordy, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic enq(input logic [31:0] ins, input bit as, input bit ordy);
    drive_cycle(1'b1, ins, 1'b1, as, ordy, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic wb(input logic [4:0] r, input bit ordy);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, ordy, 1'b1, r, 1'b0);
  endtask

  task automatic check_out(input string tag, input bit ov, input logic [31:0] ins);
    check({tag, ".a_ov"}, 32'(a_out_valid), 32'(ov));
    check({tag, ".b_ov"}, 32'(b_out_valid), 32'(ov));
    if (ov) begin
      check({tag, ".a_instr"}, a_out_instr, ins);
      check({tag, ".b_instr"}, b_out_instr, ins);
    end
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    // Reset held with enqueue requests present.
    model_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h00C58533;
    in_regwrite = 1'b1; in_alusrc = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.a_ov", 32'(a_out_valid), 32'd0);
    check("reset.a_count", 32'(a_count), 32'd0);
    check("reset.b_ov", 32'(b_out_valid), 32'd0);
    check("reset.b_count", 32'(b_count), 32'd0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("reset.a_in_ready", 32'(a_in_ready), 32'd1);
    check("reset.b_in_ready", 32'(b_in_ready), 32'd1);

    // RAW on x10: producer issues at enq+2, consumer waits for the writeback.
    enq(32'h00C58533, 1'b0, 1'b1);
    enq(32'h00A60533, 1'b0, 1'b1);
    check_out("raw.first", 1'b1, 32'h00C58533);
    idle(1, 1'b1);
    check_out("raw.held", 1'b0, '0);
    wb(5'd10, 1'b1);
    check_out("raw.wb_cycle", 1'b0, '0);
    idle(1, 1'b1);
    check_out("raw.released", 1'b1, 32'h00A60533);
    idle(1, 1'b1);

    // Out-of-order: independent younger entry overtakes two stalled older ones.
    enq(mk(10, 12, 10), 1'b0, 1'b1);
    enq(mk(12, 13, 14), 1'b1, 1'b1);
    enq(mk(14, 14, 15), 1'b0, 1'b1);
    idle(1, 1'b1);
    check("ooo.a_ov", 32'(a_out_valid), 32'd1);
    check("ooo.a_instr", a_out_instr, 32'h00F70733);
    check("ooo.b_ov", 32'(b_out_valid), 32'd0);
    idle(1, 1'b1);
    wb(5'd10, 1'b1);
    idle(1, 1'b1);
    check_out("ooo.after_wb", 1'b1, 32'h00A60533);
    idle(3, 1'b1);

    // x0 destination never marks busy; immediate form ignores busy x10 in its rs2 field.
    enq(32'h00208033, 1'b0, 1'b1);
    enq(32'h00A00293, 1'b1, 1'b1);
    check_out("x0.write", 1'b1, 32'h00208033);
    idle(1, 1'b1);
    check_out("alusrc.issue", 1'b1, 32'h00A00293);

    // Flush with three stalled entries and a held output; busy must survive.
    enq(mk(21, 10, 0), 1'b0, 1'b0);
    enq(mk(22, 10, 0), 1'b0, 1'b0);
    enq(mk(23, 10, 0), 1'b0, 1'b0);
    drive_cycle(1'b1, mk(25, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    check("flush.a_count", 32'(a_count), 32'd0);
    check("flush.b_count", 32'(b_count), 32'd0);
    check_out("flush", 1'b0, '0);
    enq(mk(24, 10, 0), 1'b0, 1'b1);
    idle(1, 1'b1);
    check_out("flush.busy_kept", 1'b0, '0);
    wb(5'd10, 1'b1);
    idle(1, 1'b0);
    check_out("flush.reissue", 1'b1, mk(24, 10, 0));
    idle(1, 1'b0);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b0;
    #1;
    check("async.a_ov", 32'(a_out_valid), 32'd0);
    check("async.b_ov", 32'(b_out_valid), 32'd0);
    check("async.a_count", 32'(a_count), 32'd0);
    check("async.b_count", 32'(b_count), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Full window and tail wrap on the DEPTH=4 copy.
    for (int i = 1; i <= 6; i++) enq(mk(5'(i), 0, 0), 1'b0, 1'b0);
    check("full.a_count", 32'(a_count), 32'd4);
    check("full.a_in_ready", 32'(a_in_ready), 32'd0);
    check("full.a_instr", a_out_instr, mk(1, 0, 0));
    check("full.b_count", 32'(b_count), 32'd5);
    for (int i = 1; i <= 6; i++) wb(5'(i), 1'b1);
    idle(3, 1'b1);

    // Randomized traffic over a small register set to keep hazards frequent.
    for (int c = 0; c < 1500; c++) begin
      r_rd = 5'($urandom_range(0, 7));
      r_rs1 = 5'($urandom_range(0, 7));
      r_rs2 = 5'($urandom_range(0, 7));
      ins = mk(r_rd, r_rs1, r_rs2);
      ins[14:12] = 3'($urandom_range(0, 7));
      drive_cycle($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
